// File: rtl/isp_awb_pkg.sv
// Shared definitions for the AWB gain calculator: FSM encoding and gain-format helpers.
package isp_awb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV_R  = 2'd1,
        ST_DIV_B  = 2'd2,
        ST_UPDATE = 2'd3
    } awb_state_e;

    function automatic int gain_width(input int gain_int, input int gain_frac);
        return gain_int + gain_frac;
    endfunction

    function automatic int unity_gain(input int gain_frac);
        return 1 << gain_frac;
    endfunction

    function automatic int sat_gain(input int q);
        return (1 << q) - 1;
    endfunction

endpackage

// File: rtl/isp_serial_div.sv
// Restoring divider, one quotient bit per cycle; o_done pulses QUO_W cycles after i_start.
module isp_serial_div #(
    parameter int DIVIDEND_W = 40,
    parameter int DIVISOR_W  = 32,
    parameter int QUO_W      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic [QUO_W-1:0]      o_quotient,
    output logic                  o_done
);

    localparam int CNT_W = $clog2(QUO_W + 1);

    logic                 r_run;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_done;
    logic [DIVISOR_W-1:0] r_rem;
    logic [QUO_W-1:0]     r_bits;
    logic [QUO_W-1:0]     r_quo;
    logic [DIVISOR_W-1:0] r_divisor;

    logic [DIVISOR_W-1:0] w_rem_src;
    logic [QUO_W-1:0]     w_bits_src;
    logic [QUO_W-1:0]     w_quo_src;
    logic [DIVISOR_W-1:0] w_div_src;
    logic [DIVISOR_W:0]   w_trial;
    logic                 w_ge;
    logic [DIVISOR_W-1:0] w_rem_next;

    // The start cycle already performs the first step, so the quotient is final after QUO_W edges.
    // The caller guarantees the quotient fits QUO_W bits, so the upper dividend bits seed a remainder below the divisor.
    always_comb begin
        w_rem_src  = i_start ? DIVISOR_W'(i_dividend >> QUO_W) : r_rem;
        w_bits_src = i_start ? i_dividend[QUO_W-1:0] : r_bits;
        w_quo_src  = i_start ? '0 : r_quo;
        w_div_src  = i_start ? i_divisor : r_divisor;
        w_trial    = {w_rem_src, w_bits_src[QUO_W-1]};
        w_ge       = (w_trial >= {1'b0, w_div_src});
        w_rem_next = DIVISOR_W'(w_ge ? (w_trial - {1'b0, w_div_src}) : w_trial);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run  <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_run  <= (QUO_W > 1);
                r_cnt  <= CNT_W'(QUO_W - 1);
                r_done <= (QUO_W == 1);
            end else if (r_run) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_start || r_run) begin
            r_rem  <= w_rem_next;
            r_bits <= w_bits_src << 1;
            r_quo  <= (w_quo_src << 1) | QUO_W'(w_ge);
        end
        if (i_start) r_divisor <= i_divisor;
    end

    assign o_quotient = r_quo;
    assign o_done     = r_done;

endmodule

// File: rtl/isp_awb_gain_calc.sv
// AWB white-balance gain calculator: gain_r = sum_g/sum_r, gain_b = sum_g/sum_b via one shared serial divider.
// Optional macro AWB_SMOOTH_EN enables IIR smoothing of the gains by SMOOTH_SHIFT.
module isp_awb_gain_calc
    import isp_awb_pkg::*;
#(
    parameter int IN_BITS      = 32,
    parameter int GAIN_INT     = 4,
    parameter int GAIN_FRAC    = 8,
    parameter int SMOOTH_SHIFT = 2,
    localparam int Q           = gain_width(GAIN_INT, GAIN_FRAC)
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               enable,
    input  logic [IN_BITS-1:0] min_cnt,
    input  logic               in_done,
    input  logic [IN_BITS-1:0] in_cnt,
    input  logic [IN_BITS-1:0] in_sum_r,
    input  logic [IN_BITS-1:0] in_sum_g,
    input  logic [IN_BITS-1:0] in_sum_b,
    output logic [Q-1:0]       out_gain_r,
    output logic [Q-1:0]       out_gain_g,
    output logic [Q-1:0]       out_gain_b,
    output logic               out_valid,
    output logic               busy
);

    localparam logic [Q-1:0] GAIN_UNITY = Q'(unity_gain(GAIN_FRAC));
    localparam logic [Q-1:0] GAIN_SAT   = Q'(sat_gain(Q));
    localparam int           DVD_W      = IN_BITS + GAIN_FRAC;

    awb_state_e         r_state;
    logic [Q-1:0]       r_gain_r;
    logic [Q-1:0]       r_gain_b;
    logic               r_valid;
    logic [IN_BITS-1:0] r_sum_g;
    logic [IN_BITS-1:0] r_sum_b;
    logic               r_sat_r;
    logic               r_sat_b;
    logic [Q-1:0]       r_calc_r;
    logic [Q-1:0]       r_calc_b;

    logic               w_accept;
    logic               w_div_start;
    logic               w_div_done;
    logic [DVD_W-1:0]   w_dividend;
    logic [IN_BITS-1:0] w_divisor;
    logic [Q-1:0]       w_quotient;
    logic [Q-1:0]       w_next_r;
    logic [Q-1:0]       w_next_b;

    // Widened compare so sum_x << GAIN_INT never loses bits.
    function automatic logic is_sat(input logic [IN_BITS-1:0] g, input logic [IN_BITS-1:0] x);
        logic [IN_BITS+GAIN_INT-1:0] g_wide;
        logic [IN_BITS+GAIN_INT-1:0] x_wide;
        g_wide = {{GAIN_INT{1'b0}}, g};
        x_wide = {x, {GAIN_INT{1'b0}}};
        return (x == '0) || (g_wide >= x_wide);
    endfunction

    function automatic logic [Q-1:0] smooth(input logic [Q-1:0] old, input logic [Q-1:0] calc);
        logic signed [Q:0]   diff;
        logic signed [Q:0]   step;
        logic signed [Q+1:0] sum;
        diff = $signed({1'b0, calc}) - $signed({1'b0, old});
        step = diff >>> SMOOTH_SHIFT;
        sum  = $signed({2'b00, old}) + $signed({step[Q], step});
        if (sum[Q+1])  return '0;
        else if (sum[Q]) return GAIN_SAT;
        else             return sum[Q-1:0];
    endfunction

    assign w_accept    = (r_state == ST_IDLE) && in_done && enable && (in_cnt >= min_cnt);
    assign w_div_start = w_accept || ((r_state == ST_DIV_R) && w_div_done);
    assign w_dividend  = (r_state == ST_IDLE) ? {in_sum_g, {GAIN_FRAC{1'b0}}}
                                              : {r_sum_g, {GAIN_FRAC{1'b0}}};
    assign w_divisor   = (r_state == ST_IDLE) ? in_sum_r : r_sum_b;

    isp_serial_div #(
        .DIVIDEND_W (DVD_W),
        .DIVISOR_W  (IN_BITS),
        .QUO_W      (Q)
    ) u_div (
        .clk        (pclk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_divisor),
        .o_quotient (w_quotient),
        .o_done     (w_div_done)
    );

`ifdef AWB_SMOOTH_EN
    assign w_next_r = smooth(r_gain_r, r_calc_r);
    assign w_next_b = smooth(r_gain_b, r_calc_b);
`else
    assign w_next_r = r_calc_r;
    assign w_next_b = r_calc_b;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gain_r <= GAIN_UNITY;
            r_gain_b <= GAIN_UNITY;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE:   if (w_accept) r_state <= ST_DIV_R;
                ST_DIV_R:  if (w_div_done) r_state <= ST_DIV_B;
                ST_DIV_B:  if (w_div_done) r_state <= ST_UPDATE;
                ST_UPDATE: begin
                    r_gain_r <= w_next_r;
                    r_gain_b <= w_next_b;
                    r_valid  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Operand latches only move on acceptance, so in_done during a computation cannot disturb them.
    always_ff @(posedge pclk) begin
        if (w_accept) begin
            r_sum_g <= in_sum_g;
            r_sum_b <= in_sum_b;
            r_sat_r <= is_sat(in_sum_g, in_sum_r);
            r_sat_b <= is_sat(in_sum_g, in_sum_b);
        end
        if ((r_state == ST_DIV_R) && w_div_done) r_calc_r <= r_sat_r ? GAIN_SAT : w_quotient;
        if ((r_state == ST_DIV_B) && w_div_done) r_calc_b <= r_sat_b ? GAIN_SAT : w_quotient;
    end

    assign out_gain_r = r_gain_r;
    assign out_gain_g = GAIN_UNITY;
    assign out_gain_b = r_gain_b;
    assign out_valid  = r_valid;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_isp_awb_gain_calc.sv
// Self-checking bench for isp_awb_gain_calc; gains are predicted by a reference model feeding a scoreboard queue.
module tb_isp_awb_gain_calc;

    localparam int IN_BITS      = 32;
    localparam int GAIN_INT     = 4;
    localparam int GAIN_FRAC    = 8;
    localparam int SMOOTH_SHIFT = 2;
    localparam int Q            = GAIN_INT + GAIN_FRAC;
    localparam int LAT          = 2*Q + 2;

    logic               pclk = 1'b0;
    logic               rst;
    logic               enable;
    logic [IN_BITS-1:0] min_cnt;
    logic               in_done;
    logic [IN_BITS-1:0] in_cnt;
    logic [IN_BITS-1:0] in_sum_r;
    logic [IN_BITS-1:0] in_sum_g;
    logic [IN_BITS-1:0] in_sum_b;
    logic [Q-1:0]       out_gain_r;
    logic [Q-1:0]       out_gain_g;
    logic [Q-1:0]       out_gain_b;
    logic               out_valid;
    logic               busy;

    isp_awb_gain_calc #(
        .IN_BITS      (IN_BITS),
        .GAIN_INT     (GAIN_INT),
        .GAIN_FRAC    (GAIN_FRAC),
        .SMOOTH_SHIFT (SMOOTH_SHIFT)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .enable     (enable),
        .min_cnt    (min_cnt),
        .in_done    (in_done),
        .in_cnt     (in_cnt),
        .in_sum_r   (in_sum_r),
        .in_sum_g   (in_sum_g),
        .in_sum_b   (in_sum_b),
        .out_gain_r (out_gain_r),
        .out_gain_g (out_gain_g),
        .out_gain_b (out_gain_b),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int r;
        int b;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   m_gain_r = 256;
    int   m_gain_b = 256;

    function automatic int calc_gain(input longint g, input longint x);
        if (x == 0 || g >= (x << GAIN_INT)) return (1 << Q) - 1;
        return int'((g << GAIN_FRAC) / x);
    endfunction

    function automatic int blend(input int old, input int calc);
`ifdef AWB_SMOOTH_EN
        int n;
        n = old + ((calc - old) >>> SMOOTH_SHIFT);
        if (n < 0) n = 0;
        if (n > (1 << Q) - 1) n = (1 << Q) - 1;
        return n;
`else
        return calc;
`endif
    endfunction

    task automatic push_expect(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
        exp_t e;
        m_gain_r = blend(m_gain_r, calc_gain(longint'(g), longint'(r)));
        m_gain_b = blend(m_gain_b, calc_gain(longint'(g), longint'(b)));
        e.r = m_gain_r;
        e.b = m_gain_b;
        exp_q.push_back(e);
    endtask

    always @(negedge pclk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: out_valid=1 with nothing pending, required no pulse");
            end else begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                if (out_gain_r !== Q'(mon_e.r)) begin
                    n_fail++;
                    $display("FAIL sb_gain_r: got %0d, required %0d", out_gain_r, mon_e.r);
                end
                n_cmp++;
                if (out_gain_b !== Q'(mon_e.b)) begin
                    n_fail++;
                    $display("FAIL sb_gain_b: got %0d, required %0d", out_gain_b, mon_e.b);
                end
                n_cmp++;
                if (out_gain_g !== Q'(256)) begin
                    n_fail++;
                    $display("FAIL sb_gain_g: got %0d, required 256", out_gain_g);
                end
            end
        end
    end

    // Drives one in_done pulse, then records busy/out_valid over the following cycles (k = cycles after t0).
    task automatic run_frame(input logic [31:0] cnt, input logic [31:0] r, input logic [31:0] g,
                             input logic [31:0] b, output int fb, output int lb, output int vc, output int vn);
        @(posedge pclk); #1;
        in_done = 1'b1; in_cnt = cnt; in_sum_r = r; in_sum_g = g; in_sum_b = b;
        @(posedge pclk); #1;
        in_done = 1'b0;
        fb = -1; lb = -1; vc = -1; vn = 0;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge pclk);
            if (busy) begin
                if (fb < 0) fb = k;
                lb = k;
            end
            if (out_valid) begin
                vn++;
                vc = k;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge pclk);
        #1 rst = 1'b0;
        m_gain_r = 256;
        m_gain_b = 256;
    endtask

    task automatic test_reset();
        enable = 1'b1; min_cnt = 32'd10; in_done = 1'b0;
        in_cnt = '0; in_sum_r = '0; in_sum_g = '0; in_sum_b = '0;
        do_reset();
        @(negedge pclk);
        n_cmp++; if (out_gain_r !== 12'd256) begin n_fail++; $display("FAIL reset_gain_r: got %0d, required 256", out_gain_r); end
        n_cmp++; if (out_gain_g !== 12'd256) begin n_fail++; $display("FAIL reset_gain_g: got %0d, required 256", out_gain_g); end
        n_cmp++; if (out_gain_b !== 12'd256) begin n_fail++; $display("FAIL reset_gain_b: got %0d, required 256", out_gain_b); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_nominal();
        int fb, lb, vc, vn;
        push_expect(32'd1000, 32'd2000, 32'd4000);
        run_frame(32'd100, 32'd1000, 32'd2000, 32'd4000, fb, lb, vc, vn);
        n_cmp++; if (vc !== LAT) begin n_fail++; $display("FAIL nom_valid_cycle: got t0+%0d, required t0+%0d", vc, LAT); end
        n_cmp++; if (vn !== 1) begin n_fail++; $display("FAIL nom_valid_count: got %0d, required 1", vn); end
        n_cmp++; if (fb !== 1) begin n_fail++; $display("FAIL nom_busy_first: got t0+%0d, required t0+1", fb); end
        n_cmp++; if (lb !== LAT - 1) begin n_fail++; $display("FAIL nom_busy_last: got t0+%0d, required t0+%0d", lb, LAT - 1); end
    endtask

    task automatic test_saturation();
        logic [31:0] tbl [5][3];
        int fb, lb, vc, vn;
        tbl[0] = '{32'd100,        32'd2000,       32'd0};
        tbl[1] = '{32'd1000,       32'd16000,      32'd16000};
        tbl[2] = '{32'd1000,       32'd15999,      32'd16000};
        tbl[3] = '{32'h1000_0000,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
        tbl[4] = '{32'd0,          32'd0,          32'd1};
        for (int i = 0; i < 5; i++) begin
            push_expect(tbl[i][0], tbl[i][1], tbl[i][2]);
            run_frame(32'd100, tbl[i][0], tbl[i][1], tbl[i][2], fb, lb, vc, vn);
            n_cmp++; if (vn !== 1 || vc !== LAT) begin n_fail++; $display("FAIL sat_frame%0d: valid count %0d at t0+%0d, required 1 at t0+%0d", i, vn, vc, LAT); end
        end
    endtask

    task automatic test_count_gating();
        int fb, lb, vc, vn;
        min_cnt = 32'd10;
        run_frame(32'd5, 32'd300, 32'd2000, 32'd700, fb, lb, vc, vn);
        n_cmp++; if (vn !== 0) begin n_fail++; $display("FAIL gate_low_valid: got %0d pulses, required 0", vn); end
        n_cmp++; if (fb !== -1) begin n_fail++; $display("FAIL gate_low_busy: busy seen at t0+%0d, required never", fb); end
        n_cmp++; if (out_gain_r !== Q'(m_gain_r)) begin n_fail++; $display("FAIL gate_low_hold_r: got %0d, required %0d", out_gain_r, m_gain_r); end
        n_cmp++; if (out_gain_b !== Q'(m_gain_b)) begin n_fail++; $display("FAIL gate_low_hold_b: got %0d, required %0d", out_gain_b, m_gain_b); end
        push_expect(32'd300, 32'd2000, 32'd700);
        run_frame(32'd10, 32'd300, 32'd2000, 32'd700, fb, lb, vc, vn);
        n_cmp++; if (vn !== 1 || vc !== LAT) begin n_fail++; $display("FAIL gate_equal: valid count %0d at t0+%0d, required 1 at t0+%0d", vn, vc, LAT); end
    endtask

    task automatic test_enable();
        int fb, lb, vc, vn;
        enable = 1'b0;
        run_frame(32'd100, 32'd1000, 32'd2000, 32'd4000, fb, lb, vc, vn);
        enable = 1'b1;
        n_cmp++; if (vn !== 0) begin n_fail++; $display("FAIL en_off_valid: got %0d pulses, required 0", vn); end
        n_cmp++; if (fb !== -1) begin n_fail++; $display("FAIL en_off_busy: busy seen at t0+%0d, required never", fb); end
        n_cmp++; if (out_gain_r !== Q'(m_gain_r)) begin n_fail++; $display("FAIL en_off_hold_r: got %0d, required %0d", out_gain_r, m_gain_r); end
    endtask

    task automatic test_busy_drop();
        int vc, vn;
        vc = -1; vn = 0;
        push_expect(32'd1000, 32'd2000, 32'd4000);
        @(posedge pclk); #1;
        in_done = 1'b1; in_cnt = 32'd100; in_sum_r = 32'd1000; in_sum_g = 32'd2000; in_sum_b = 32'd4000;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(posedge pclk); #1;
            in_done = (k == 5);
            if (k == 5) begin
                in_sum_r = 32'd50; in_sum_g = 32'd3000; in_sum_b = 32'd9000;
            end
            @(negedge pclk);
            if (out_valid) begin
                vn++;
                vc = k;
            end
        end
        n_cmp++; if (vn !== 1) begin n_fail++; $display("FAIL drop_valid_count: got %0d, required 1", vn); end
        n_cmp++; if (vc !== LAT) begin n_fail++; $display("FAIL drop_valid_cycle: got t0+%0d, required t0+%0d", vc, LAT); end
    endtask

    task automatic test_back_to_back();
        int vn, v1, v2;
        vn = 0; v1 = -1; v2 = -1;
        push_expect(32'd400, 32'd1000, 32'd250);
        push_expect(32'd3000, 32'd1500, 32'd600);
        @(posedge pclk); #1;
        in_done = 1'b1; in_cnt = 32'd50; in_sum_r = 32'd400; in_sum_g = 32'd1000; in_sum_b = 32'd250;
        for (int k = 1; k <= 2*LAT + 2; k++) begin
            @(posedge pclk); #1;
            in_done = (k == LAT);
            if (k == LAT) begin
                in_sum_r = 32'd3000; in_sum_g = 32'd1500; in_sum_b = 32'd600;
            end
            @(negedge pclk);
            if (out_valid) begin
                vn++;
                if (v1 < 0) v1 = k; else v2 = k;
            end
        end
        n_cmp++; if (vn !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d, required 2", vn); end
        n_cmp++; if (v2 !== 2*LAT) begin n_fail++; $display("FAIL b2b_second: got t0+%0d, required t0+%0d", v2, 2*LAT); end
    endtask

    task automatic test_reset_mid();
        int vn, fb, lb, vc, vn2;
        vn = 0;
        n_cmp++; if (out_gain_r !== Q'(m_gain_r)) begin n_fail++; $display("FAIL rmid_pre_gain_r: got %0d, required %0d", out_gain_r, m_gain_r); end
        @(posedge pclk); #1;
        in_done = 1'b1; in_cnt = 32'd100; in_sum_r = 32'd500; in_sum_g = 32'd2000; in_sum_b = 32'd1000;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(posedge pclk); #1;
            in_done = 1'b0;
            rst = (k == 10);
            @(negedge pclk);
            if (out_valid) vn++;
            if (k == 11) begin
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b, required 0", busy); end
                n_cmp++; if (out_gain_r !== 12'd256) begin n_fail++; $display("FAIL rmid_gain_r: got %0d, required 256", out_gain_r); end
                n_cmp++; if (out_gain_b !== 12'd256) begin n_fail++; $display("FAIL rmid_gain_b: got %0d, required 256", out_gain_b); end
            end
        end
        m_gain_r = 256;
        m_gain_b = 256;
        n_cmp++; if (vn !== 0) begin n_fail++; $display("FAIL rmid_no_valid: got %0d pulses, required 0", vn); end
        push_expect(32'd1000, 32'd2000, 32'd4000);
        run_frame(32'd100, 32'd1000, 32'd2000, 32'd4000, fb, lb, vc, vn2);
        n_cmp++; if (vn2 !== 1 || vc !== LAT) begin n_fail++; $display("FAIL rmid_fresh: valid count %0d at t0+%0d, required 1 at t0+%0d", vn2, vc, LAT); end
    endtask

`ifdef AWB_SMOOTH_EN
    task automatic test_smooth();
        int fb, lb, vc, vn;
        do_reset();
        push_expect(32'd1000, 32'd2000, 32'd4000);
        run_frame(32'd100, 32'd1000, 32'd2000, 32'd4000, fb, lb, vc, vn);
        n_cmp++; if (out_gain_r !== 12'd320) begin n_fail++; $display("FAIL smooth_r1: got %0d, required 320", out_gain_r); end
        n_cmp++; if (out_gain_b !== 12'd224) begin n_fail++; $display("FAIL smooth_b1: got %0d, required 224", out_gain_b); end
        push_expect(32'd1000, 32'd2000, 32'd4000);
        run_frame(32'd100, 32'd1000, 32'd2000, 32'd4000, fb, lb, vc, vn);
        n_cmp++; if (out_gain_r !== 12'd368) begin n_fail++; $display("FAIL smooth_r2: got %0d, required 368", out_gain_r); end
        n_cmp++; if (out_gain_b !== 12'd200) begin n_fail++; $display("FAIL smooth_b2: got %0d, required 200", out_gain_b); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AWB_SMOOTH_EN
        test_smooth();
`endif
        test_nominal();
        test_saturation();
        test_count_gating();
        test_enable();
        test_busy_drop();
        test_back_to_back();
        test_nominal();
        test_reset_mid();
        repeat (4) @(negedge pclk);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected results never produced, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/isp_awb_gain_calc.md
Name: isp_awb_gain_calc

Overview:
Downstream consumer of the AWB statistics interface (done pulse, valid-pixel count, per-channel sums). On each qualifying frame it computes the white-balance gains gain_r = sum_g/sum_r and gain_b = sum_g/sum_b as unsigned fixed-point values; gain_g is fixed at unity. The gains are held stable for the ISP white-balance multiplier stage. A single shared serial divider computes both gains, so the block is multi-cycle and reports busy.

Parameters:
IN_BITS, 32, width of the count and sum inputs; matches the statistics OUT_BITS.
GAIN_INT, 4, integer bits of a gain.
GAIN_FRAC, 8, fractional bits of a gain; gain width Q = GAIN_INT+GAIN_FRAC.
SMOOTH_SHIFT, 2, IIR shift; used only with AWB_SMOOTH_EN.

Ports:
pclk  in  1  pixel clock; the only clock
rst  in  1  synchronous reset, active-high
enable  in  1  1 = accept statistics; sampled only on the in_done cycle
min_cnt  in  IN_BITS  minimum valid-pixel count for a frame to be used
in_done  in  1  one-cycle pulse: in_cnt and in_sum_* are valid and stable
in_cnt  in  IN_BITS  valid-pixel count for the frame
in_sum_r / in_sum_g / in_sum_b  in  IN_BITS each  per-channel sums for the frame
out_gain_r / out_gain_g / out_gain_b  out  Q each  gains, unsigned, GAIN_FRAC fractional bits
out_valid  out  1  one-cycle pulse when new gains take effect
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at a pclk edge): state IDLE; all gains = 1<<GAIN_FRAC (unity, 256 at defaults); out_valid=0; busy=0. Reset in the middle of a computation abandons it and discards any partial result.
- FSM states: IDLE, DIV_R, DIV_B, UPDATE.
- IDLE: if in_done && enable && in_cnt >= min_cnt:
  - latch in_sum_r, in_sum_g and in_sum_b;
  - precompute the saturation flags;
  - go to DIV_R.
  Otherwise stay in IDLE and leave the gains unchanged. A frame rejected by the count check never produces out_valid.
- DIV_R: lasts exactly Q cycles; the restoring divider produces one quotient bit per cycle for sum_g*2^GAIN_FRAC / sum_r.
- DIV_B: the same divider runs for sum_b, Q cycles.
- UPDATE: lasts 1 cycle; registers the final gains; returns to IDLE.
- Timing, with the accepted in_done at cycle t0:
  - DIV_R occupies t0+1..t0+Q;
  - DIV_B occupies t0+Q+1..t0+2Q;
  - UPDATE is at t0+2Q+1;
  - new gains and out_valid are visible at t0+2Q+2 (cycle t0+26 at defaults).
  busy is high from t0+1 through t0+2Q+1.
- in_done while busy is ignored: the frame is dropped and the latched operands are not disturbed.
- Arithmetic:
  - gain = floor(sum_g * 2^GAIN_FRAC / sum_x).
  - Saturation: if sum_x == 0, or sum_g >= (sum_x << GAIN_INT), the gain is 2^Q-1 (4095 at defaults). In that case the divider result is discarded.
  - Comparisons use IN_BITS+GAIN_INT bit widths, so the shift cannot overflow.
- out_gain_g is constant at 1<<GAIN_FRAC.

Optional Feature:
AWB_SMOOTH_EN
- Defined: in UPDATE, each of R and B becomes gain_new = gain_old + ((calc - gain_old) >>> SMOOTH_SHIFT).
  - The subtraction is done in Q+1-bit signed arithmetic; the shift is arithmetic, flooring toward negative infinity.
  - The result is clamped to the range [0, 2^Q-1].
- Undefined: gain_new = calc. The SMOOTH_SHIFT parameter is ignored.
- Latency is identical in both cases.

Decomposition:
- Package isp_awb_pkg holds:
  - the FSM state encoding;
  - the function computing Q from GAIN_INT and GAIN_FRAC;
  - the unity and saturation gain constants.
- Sub-module isp_serial_div: restoring divider.
  - Parameters: dividend width, divisor width, quotient width.
  - Interface: start, dividend, divisor; outputs quotient and a done pulse after exactly Q cycles.
  - It is instantiated once and reused for the R and B divisions.

Test Plan:
- Nominal (defaults): min_cnt=10; in_done with cnt=100, sum_r=1000, sum_g=2000, sum_b=4000 -> at t0+26, out_valid=1 for 1 cycle; gain_r=512, gain_b=128, gain_g=256. busy is high for t0+1..t0+25.
- Saturation and zero: sum_r=100, sum_g=2000, sum_b=0 -> gain_r=4095 (ratio 20 >= 16) and gain_b=4095.
- Count gating and enable:
  - cnt=5 with min_cnt=10 -> no out_valid, gains stay at 256, busy stays 0;
  - enable=0 with valid statistics -> the same result.
- Busy drop: a second in_done at t0+5 carrying different sums -> the output still reflects the first frame (512/128); exactly one out_valid is produced.
- Reset mid-operation: rst=1 at t0+10 after a prior update to 512 -> next cycle busy=0, gains=256, no out_valid afterwards; a fresh frame then computes correctly.
- AWB_SMOOTH_EN, SMOOTH_SHIFT=2: from reset (gain_r=256), target 512 -> gain_r=320, then 368 on the same stats; target 128 from 256 -> 224.
